// File: rtl/led_flasher_pkg.sv
// Shared types and widths for the LED flasher: state encoding, timer width, queue width.
package led_flasher_pkg;

  localparam int TIMER_W = 25;
  localparam int QUEUE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } flashState_t;

endpackage

// File: rtl/flash_timer.sv
// Loadable down-counter shared by the ON and OFF phases; done marks the final cycle of a phase.
module flash_timer
  import led_flasher_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] value,
  output logic               done
);

  logic [TIMER_W-1:0] count;

  // Loading value-1 makes a phase of N cycles end with done on its N-th cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= value - TIMER_W'(1);
    end else if (count != '0) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/led_flasher.sv
// Queued LED flasher: each request gives one ON pulse followed by a dark gap.
// Optional dimming of the ON phase is enabled by defining LED_FLASHER_DIM_EN.
module led_flasher
  import led_flasher_pkg::*;
#(
  parameter logic [TIMER_W-1:0] ON_CYCLES  = 25'd10_000_000,
  parameter logic [TIMER_W-1:0] OFF_CYCLES = 25'd10_000_000,
  parameter logic [QUEUE_W-1:0] QUEUE_MAX  = 4'd15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               eventIn,
  input  logic               clearIn,
`ifdef LED_FLASHER_DIM_EN
  input  logic [3:0]         dutyIn,
`endif
  output logic               ledOut,
  output logic               busy,
  output logic [QUEUE_W-1:0] pending,
  output logic               overflow
);

  flashState_t        state;
  flashState_t        stateNext;
  logic               haveWork;
  logic               startFlash;
  logic               endFlash;
  logic               queueEvent;
  logic               takeQueued;
  logic               timerLoad;
  logic [TIMER_W-1:0] timerValue;
  logic               timerDone;
  logic               dimGate;

  flash_timer phaseTimer (
    .clock (clock),
    .reset (reset),
    .load  (timerLoad),
    .value (timerValue),
    .done  (timerDone)
  );

  always_comb begin
    haveWork   = eventIn || (pending != '0);
    startFlash = 1'b0;
    endFlash   = 1'b0;
    unique case (state)
      IDLE:    startFlash = haveWork;
      ON:      endFlash   = timerDone;
      OFF:     startFlash = timerDone && haveWork;
      default: ;
    endcase
    if (clearIn) begin
      startFlash = 1'b0;
      endFlash   = 1'b0;
    end

    stateNext = state;
    if (clearIn)
      stateNext = IDLE;
    else if (startFlash)
      stateNext = ON;
    else if (endFlash)
      stateNext = OFF;
    else if ((state == OFF) && timerDone)
      stateNext = IDLE;

    // A flash consumes the same-cycle request first; only otherwise does it drain the queue.
    queueEvent = eventIn && !clearIn && !startFlash;
    takeQueued = startFlash && !eventIn;
    timerLoad  = startFlash || endFlash;
    timerValue = startFlash ? ON_CYCLES : OFF_CYCLES;
  end

`ifdef LED_FLASHER_DIM_EN
  logic [3:0] pwmCount;
  logic [3:0] pwmNext;

  assign pwmNext = pwmCount + 4'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      pwmCount <= 4'd0;
    else
      pwmCount <= pwmNext;
  end

  // Compare against the count that will be live when the registered LED takes effect.
  assign dimGate = (pwmNext < dutyIn);
`else
  assign dimGate = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ledOut   <= 1'b0;
      busy     <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      state  <= stateNext;
      busy   <= (stateNext != IDLE);
      ledOut <= (stateNext == ON) && dimGate;
      if (clearIn) begin
        pending  <= '0;
        overflow <= 1'b0;
      end else if (queueEvent) begin
        if (pending == QUEUE_MAX)
          overflow <= 1'b1;
        else
          pending <= pending + QUEUE_W'(1);
      end else if (takeQueued) begin
        pending <= pending - QUEUE_W'(1);
      end
    end
  end

  paramCheck: assert property (@(posedge clock)
    (ON_CYCLES != '0) && (OFF_CYCLES != '0) && (QUEUE_MAX != '0));

endmodule

// File: tb/tb_led_flasher.sv
// Self-checking bench for led_flasher: directed timing scenarios plus random traffic against a phase model.
module tb_led_flasher;

`ifdef LED_FLASHER_DIM_EN
  localparam logic [24:0] ON_P = 25'd32;
`else
  localparam logic [24:0] ON_P = 25'd4;
`endif
  localparam logic [24:0] OFF_P  = 25'd3;
  localparam logic [3:0]  QMAX_P = 4'd3;

  logic       clock   = 1'b0;
  logic       reset   = 1'b0;
  logic       eventIn = 1'b0;
  logic       clearIn = 1'b0;
  logic       ledOut;
  logic       busy;
  logic [3:0] pending;
  logic       overflow;
`ifdef LED_FLASHER_DIM_EN
  logic [3:0] dutyIn = 4'd0;
`endif

  int nCompared   = 0;
  int nMismatched = 0;
  int cyc         = 0;

  // Model: cycles of busy time left in the current flash, plus queue depth and sticky flag.
  int mRem = 0;
  int mQ   = 0;
  bit mOvf = 1'b0;

  led_flasher #(
    .ON_CYCLES  (ON_P),
    .OFF_CYCLES (OFF_P),
    .QUEUE_MAX  (QMAX_P)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .eventIn  (eventIn),
    .clearIn  (clearIn),
`ifdef LED_FLASHER_DIM_EN
    .dutyIn   (dutyIn),
`endif
    .ledOut   (ledOut),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] observed();
    return {ledOut, busy, pending, overflow};
  endfunction

  task automatic step(input logic ev, input logic clr);
    eventIn = ev;
    clearIn = clr;
    if (ev || clr) $display("req cyc=%0d event=%0b clear=%0b", cyc, ev, clr);
    @(posedge clock);
    #1;
    cyc++;
    eventIn = 1'b0;
    clearIn = 1'b0;
  endtask

  task automatic restart();
    eventIn = 1'b0;
    clearIn = 1'b0;
    reset   = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    cyc   = 0;
  endtask

  task automatic model_step(input logic ev, input logic clr);
    if (clr) begin
      mRem = 0;
      mQ   = 0;
      mOvf = 1'b0;
    end else if ((mRem <= 1) && (ev || mQ > 0)) begin
      mRem = int'(ON_P) + int'(OFF_P);
      if (!ev) mQ--;
    end else begin
      if (mRem > 0) mRem--;
      if (ev) begin
        if (mQ == int'(QMAX_P)) mOvf = 1'b1;
        else mQ++;
      end
    end
  endtask

  task automatic test_reset();
    logic [6:0] got;
    reset   = 1'b0;
    eventIn = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    got = observed();
    nCompared++;
    if (got !== 7'd0) begin
      nMismatched++;
      $display("FAIL reset_hold got=%b want=%b", got, 7'd0);
    end
    eventIn = 1'b0;
    reset   = 1'b1;
    cyc     = 0;
    for (int t = 0; t < 6; t++) begin
      step(1'b0, 1'b0);
      got = observed();
      nCompared++;
      if (got !== 7'd0) begin
        nMismatched++;
        $display("FAIL reset_release cyc=%0d got=%b want=%b", cyc, got, 7'd0);
      end
    end
  endtask

  task automatic test_single();
    logic [6:0] got, want;
    restart();
    for (int t = 0; t < 26; t++) begin
      step(t == 10, 1'b0);
      want = {(cyc >= 11 && cyc <= 14), (cyc >= 11 && cyc <= 17), 4'd0, 1'b0};
      got  = observed();
      nCompared++;
      if (got !== want) begin
        nMismatched++;
        $display("FAIL single cyc=%0d got=%b want=%b", cyc, got, want);
      end
    end
  endtask

  task automatic test_burst();
    logic [6:0] got, want;
    logic [3:0] pw;
    logic       lw;
    restart();
    for (int t = 0; t < 35; t++) begin
      step(t >= 10 && t <= 12, 1'b0);
      pw = (cyc < 12) ? 4'd0 : (cyc == 12) ? 4'd1 : (cyc <= 17) ? 4'd2 : (cyc <= 24) ? 4'd1 : 4'd0;
      lw = (cyc >= 11 && cyc <= 14) || (cyc >= 18 && cyc <= 21) || (cyc >= 25 && cyc <= 28);
      want = {lw, (cyc >= 11 && cyc <= 31), pw, 1'b0};
      got  = observed();
      nCompared++;
      if (got !== want) begin
        nMismatched++;
        $display("FAIL burst cyc=%0d got=%b want=%b", cyc, got, want);
      end
    end
  endtask

  task automatic test_overflow();
    logic [6:0] got, want;
    logic [3:0] pw;
    logic       lw;
    restart();
    for (int t = 0; t < 45; t++) begin
      step(t >= 10 && t <= 14, 1'b0);
      pw = (cyc < 12) ? 4'd0 : (cyc == 12) ? 4'd1 : (cyc == 13) ? 4'd2 : (cyc <= 17) ? 4'd3 :
           (cyc <= 24) ? 4'd2 : (cyc <= 31) ? 4'd1 : 4'd0;
      lw = (cyc >= 11 && cyc <= 14) || (cyc >= 18 && cyc <= 21) ||
           (cyc >= 25 && cyc <= 28) || (cyc >= 32 && cyc <= 35);
      want = {lw, (cyc >= 11 && cyc <= 38), pw, (cyc >= 15)};
      got  = observed();
      nCompared++;
      if (got !== want) begin
        nMismatched++;
        $display("FAIL overflow cyc=%0d got=%b want=%b", cyc, got, want);
      end
    end
  endtask

  task automatic test_abort();
    logic [6:0] got, want;
    logic [3:0] pw;
    restart();
    for (int t = 0; t < 30; t++) begin
      step(t >= 9 && t <= 12, t == 12);
      pw = (cyc == 11) ? 4'd1 : (cyc == 12) ? 4'd2 : 4'd0;
      if (cyc <= 12) want = {(cyc >= 10), (cyc >= 10), pw, 1'b0};
      else           want = 7'd0;
      got = observed();
      nCompared++;
      if (got !== want) begin
        nMismatched++;
        $display("FAIL abort cyc=%0d got=%b want=%b", cyc, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_off();
    logic [6:0] got;
    restart();
    for (int t = 0; t < 16; t++) step(t >= 10 && t <= 14, 1'b0);
    got = observed();
    nCompared++;
    if (got !== {1'b0, 1'b1, 4'd3, 1'b1}) begin
      nMismatched++;
      $display("FAIL mid_off_pre cyc=%0d got=%b want=%b", cyc, got, {1'b0, 1'b1, 4'd3, 1'b1});
    end
    reset = 1'b0;
    #2;
    got = observed();
    nCompared++;
    if (got !== 7'd0) begin
      nMismatched++;
      $display("FAIL mid_off_async got=%b want=%b", got, 7'd0);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int t = 0; t < 20; t++) begin
      step(1'b0, 1'b0);
      got = observed();
      nCompared++;
      if (got !== 7'd0) begin
        nMismatched++;
        $display("FAIL mid_off_after cyc=%0d got=%b want=%b", cyc, got, 7'd0);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] got, want;
    logic       ev, clr, lw;
    restart();
    mRem = 0;
    mQ   = 0;
    mOvf = 1'b0;
    for (int t = 0; t < 400; t++) begin
      ev  = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 29) == 0);
      step(ev, clr);
      model_step(ev, clr);
`ifdef LED_FLASHER_DIM_EN
      lw = 1'b0;
`else
      lw = (mRem > int'(OFF_P));
`endif
      want = {lw, (mRem > 0), 4'(mQ), mOvf};
      got  = observed();
      nCompared++;
      if (got !== want) begin
        nMismatched++;
        $display("FAIL random cyc=%0d got=%b want=%b", cyc, got, want);
      end
    end
  endtask

`ifdef LED_FLASHER_DIM_EN
  task automatic test_dim();
    int litCount, busyCount;
    for (int pass = 0; pass < 2; pass++) begin
      restart();
      dutyIn    = (pass == 0) ? 4'd8 : 4'd0;
      litCount  = 0;
      busyCount = 0;
      step(1'b1, 1'b0);
      for (int t = 0; t < 45; t++) begin
        if (ledOut) litCount++;
        if (busy) busyCount++;
        step(1'b0, 1'b0);
      end
      nCompared++;
      if (litCount != ((pass == 0) ? 16 : 0)) begin
        nMismatched++;
        $display("FAIL dim_lit duty=%0d got=%0d want=%0d", dutyIn, litCount, (pass == 0) ? 16 : 0);
      end
      nCompared++;
      if (busyCount != int'(ON_P) + int'(OFF_P)) begin
        nMismatched++;
        $display("FAIL dim_busy duty=%0d got=%0d want=%0d", dutyIn, busyCount, int'(ON_P) + int'(OFF_P));
      end
    end
    dutyIn = 4'd0;
  endtask
`endif

  initial begin
    test_reset();
`ifdef LED_FLASHER_DIM_EN
    test_dim();
`else
    test_single();
    test_burst();
    test_overflow();
    test_abort();
    test_reset_mid_off();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
